regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (dataW/rsW/RegWEn) between NREQ

---
 rtl/regfile_wb_arbiter.sv | 78 +++++++
 tb/tb_regfile_wb_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port
// among NREQ write-back requesters, with a contention counter.
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 16,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic              hold_i,
  output logic [DW-1:0]     dataW_o,
  output logic [AW-1:0]     rsW_o,
  output logic              RegWEn_o,
  output logic [IW-1:0]     grant_id_o,
  output logic [CNTW-1:0]   contend_cnt_o
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic          acc;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;
  logic [IW-1:0] ptr_nxt;
  logic          contend;

  // scan from ptr upward, wrapping at NREQ
  always_comb begin
    req_ready_o = '0;
    gnt         = '0;
    acc         = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!hold_i && !acc && req_valid_i[j]) begin
        acc            = 1'b1;
        req_ready_o[j] = 1'b1;
        gnt            = j[IW-1:0];
      end
    end
  end

  assign gnt_addr = req_addr_i[gnt*AW +: AW];
  assign gnt_data = req_data_i[gnt*DW +: DW];
  assign ptr_nxt  = (gnt == IW'(NREQ-1)) ? '0 : gnt + 1'b1;
  assign contend  = !hold_i &&
                    ($countones(req_valid_i) >= 2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr           <= '0;
      RegWEn_o      <= 1'b0;
      dataW_o       <= '0;
      rsW_o         <= '0;
      grant_id_o    <= '0;
      contend_cnt_o <= '0;
    end else begin
      RegWEn_o <= 1'b0;
      if (acc) begin
        ptr        <= ptr_nxt;
        rsW_o      <= gnt_addr;
        dataW_o    <= gnt_data;
        grant_id_o <= gnt;
        // x0 writes are consumed but never reach the file
        RegWEn_o   <= (gnt_addr != '0);
      end
      if (contend && (contend_cnt_o != '1))
        contend_cnt_o <= contend_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter,
// plus reset and saturation sequences.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_ni;
  logic [1:0]  valid;
  logic [9:0]  addr;
  logic [63:0] data;
  logic        hold;

  logic [1:0]  rdy_a, rdy_b;
  logic [31:0] dw_a, dw_b;
  logic [4:0]  rs_a, rs_b;
  logic        we_a, we_b;
  logic [0:0]  gid_a, gid_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int total = 0;
  int passed = 0;

  regfile_wb_arbiter #(.NREQ(2), .DW(32), .AW(5), .CNTW(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(valid), .req_addr_i(addr),
    .req_data_i(data), .req_ready_o(rdy_a),
    .hold_i(hold), .dataW_o(dw_a), .rsW_o(rs_a),
    .RegWEn_o(we_a), .grant_id_o(gid_a),
    .contend_cnt_o(cnt_a)
  );

  regfile_wb_arbiter #(.NREQ(2), .DW(32), .AW(5), .CNTW(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(valid), .req_addr_i(addr),
    .req_data_i(data), .req_ready_o(rdy_b),
    .hold_i(hold), .dataW_o(dw_b), .rsW_o(rs_b),
    .RegWEn_o(we_b), .grant_id_o(gid_b),
    .contend_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic        hold;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  rdy;
    logic        we;
    logic [4:0]  rs;
    logic [31:0] dw;
    logic        gid;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{2'b01, 0, 5, 0, 32'hDEADBEEF, 0,
                2'b01, 1, 5, 32'hDEADBEEF, 0, 0};
    tbl[1]  = '{2'b00, 0, 0, 0, 0, 0,
                2'b00, 0, 5, 32'hDEADBEEF, 0, 0};
    tbl[2]  = '{2'b10, 0, 0, 0, 0, 32'h1234,
                2'b10, 0, 0, 32'h1234, 1, 0};
    tbl[3]  = '{2'b11, 0, 3, 7, 32'hA0, 32'hB1,
                2'b01, 1, 3, 32'hA0, 0, 1};
    tbl[4]  = '{2'b11, 0, 3, 7, 32'hA0, 32'hB1,
                2'b10, 1, 7, 32'hB1, 1, 2};
    tbl[5]  = '{2'b11, 0, 3, 7, 32'hA0, 32'hB1,
                2'b01, 1, 3, 32'hA0, 0, 3};
    tbl[6]  = '{2'b11, 0, 3, 7, 32'hA0, 32'hB1,
                2'b10, 1, 7, 32'hB1, 1, 4};
    tbl[7]  = '{2'b01, 0, 9, 0, 32'h99, 0,
                2'b01, 1, 9, 32'h99, 0, 4};
    tbl[8]  = '{2'b11, 1, 3, 7, 32'hA0, 32'hB1,
                2'b00, 0, 9, 32'h99, 0, 4};
    tbl[9]  = '{2'b11, 1, 3, 7, 32'hA0, 32'hB1,
                2'b00, 0, 9, 32'h99, 0, 4};
    tbl[10] = '{2'b11, 1, 3, 7, 32'hA0, 32'hB1,
                2'b00, 0, 9, 32'h99, 0, 4};
    tbl[11] = '{2'b11, 0, 3, 7, 32'hA0, 32'hB1,
                2'b10, 1, 7, 32'hB1, 1, 5};

    rst_ni = 1'b0;
    valid  = '0;
    addr   = '0;
    data   = '0;
    hold   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we_a, 0);
    chk("rst_rs", rs_a, 0);
    chk("rst_dw", dw_a, 0);
    chk("rst_gid", gid_a, 0);
    chk("rst_cnt", cnt_a, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      valid = tbl[i].valid;
      hold  = tbl[i].hold;
      addr  = {tbl[i].a1, tbl[i].a0};
      data  = {tbl[i].d1, tbl[i].d0};
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), rdy_a, tbl[i].rdy);
      chk($sformatf("v%0d_rdy4", i), rdy_b, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), we_a, tbl[i].we);
      chk($sformatf("v%0d_rs", i), rs_a, tbl[i].rs);
      chk($sformatf("v%0d_dw", i), dw_a, tbl[i].dw);
      chk($sformatf("v%0d_gid", i), gid_a, tbl[i].gid);
      chk($sformatf("v%0d_cnt", i), cnt_a, tbl[i].cnt);
      chk($sformatf("v%0d_cnt4", i), cnt_b, tbl[i].cnt);
    end

    // ptr is 0 now; next accept drives a write
    valid = 2'b11;
    hold  = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_we", we_a, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_we", we_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_cnt4", cnt_b, 0);
    chk("mid_rst_rs", rs_a, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_rdy", rdy_a, 2'b01);
    @(posedge clk);
    #1;
    chk("post_rst_gid", gid_a, 0);
    chk("post_rst_rs", rs_a, 3);
    chk("post_rst_we", we_a, 1);
    chk("post_rst_cnt", cnt_a, 1);

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_cnt", i), cnt_a, i + 2);
      chk($sformatf("sat%0d_cnt4", i), cnt_b,
          (i + 2 > 15) ? 15 : i + 2);
      chk($sformatf("sat%0d_we", i), we_a, 1);
      chk($sformatf("sat%0d_gid", i), gid_a, (i + 1) % 2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
